// File: rtl/instr_ram_arbiter.sv
// Shares the instruction RAM wrapper port between core fetch (priority) and a debug/loader port.
// Optional boot-region write protection for the debug port: define INSTR_ARB_BOOT_WP_EN.
//
// state     | meaning
// CORE_PRIO | core wins; dbg gets through when core is idle or after MAX_WAIT denied cycles
// DBG_BURST | dbg owns the port for up to BURST_LEN grants or until it drops its request
module instr_ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    input  logic                    dbg_req_i,
    input  logic                    dbg_we_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dbg_rdata_o,
    output logic                    dbg_err_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    typedef enum logic {
        CORE_PRIO = 1'b0,
        DBG_BURST = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_burst_cnt;
    logic        r_core_own;
    logic        r_dbg_own;
    logic        w_dbg_win;
    logic        w_core_gnt;
    logic        w_dbg_gnt;
    logic        w_wp_block;

    always_comb begin
        w_dbg_win = 1'b0;
        if (r_state == DBG_BURST)
            w_dbg_win = dbg_req_i;
        else
            w_dbg_win = dbg_req_i & (~core_req_i | (r_wait_cnt == 8'(MAX_WAIT)));
    end

    // Grants are suppressed during reset so nothing can reach the RAM or produce a response.
    assign w_dbg_gnt  = ~rst & w_dbg_win;
    assign w_core_gnt = ~rst & core_req_i & ~w_dbg_win;

`ifdef INSTR_ARB_BOOT_WP_EN
    logic r_dbg_err;
    assign w_wp_block = w_dbg_gnt & dbg_we_i & dbg_addr_i[ADDR_WIDTH-1];
`else
    assign w_wp_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CORE_PRIO;
            r_wait_cnt  <= 8'd0;
            r_burst_cnt <= 8'd0;
            r_core_own  <= 1'b0;
            r_dbg_own   <= 1'b0;
`ifdef INSTR_ARB_BOOT_WP_EN
            r_dbg_err   <= 1'b0;
`endif
        end else begin
            r_core_own <= w_core_gnt;
            r_dbg_own  <= w_dbg_gnt;
`ifdef INSTR_ARB_BOOT_WP_EN
            r_dbg_err  <= w_wp_block;
`endif
            case (r_state)
                CORE_PRIO: begin
                    if (w_dbg_gnt) begin
                        r_wait_cnt  <= 8'd0;
                        r_burst_cnt <= 8'd1;
                        if (BURST_LEN > 1)
                            r_state <= DBG_BURST;
                    end else if (dbg_req_i) begin
                        if (r_wait_cnt != 8'hFF)
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                    end else begin
                        r_wait_cnt <= 8'd0;
                    end
                end
                DBG_BURST: begin
                    r_wait_cnt <= 8'd0;
                    if (!dbg_req_i) begin
                        r_state     <= CORE_PRIO;
                        r_burst_cnt <= 8'd0;
                    end else if (r_burst_cnt == 8'(BURST_LEN - 1)) begin
                        r_state     <= CORE_PRIO;
                        r_burst_cnt <= 8'd0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: r_state <= CORE_PRIO;
            endcase
        end
    end

    assign core_gnt_o  = w_core_gnt;
    assign dbg_gnt_o   = w_dbg_gnt;
    assign ram_en_o    = (w_core_gnt | w_dbg_gnt) & ~w_wp_block;
    assign ram_we_o    = w_dbg_gnt & dbg_we_i;
    assign ram_addr_o  = w_dbg_gnt ? dbg_addr_i : (w_core_gnt ? core_addr_i : '0);
    assign ram_wdata_o = w_dbg_gnt ? dbg_wdata_i : '0;
    assign ram_be_o    = w_dbg_gnt ? dbg_be_i : (w_core_gnt ? '1 : '0);

    assign core_rvalid_o = r_core_own & ~rst;
    assign dbg_rvalid_o  = r_dbg_own & ~rst;
    assign core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;
    assign dbg_rdata_o   = dbg_rvalid_o ? ram_rdata_i : '0;

`ifdef INSTR_ARB_BOOT_WP_EN
    assign dbg_err_o = dbg_rvalid_o & r_dbg_err;
`else
    assign dbg_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Bench for instr_ram_arbiter: directed cycle vectors plus random traffic, checked by a
// response scoreboard against a shadow copy of the RAM model contents.
module tb_instr_ram_arbiter;

    localparam int MAX_WAIT = 4;
`ifdef INSTR_ARB_BOOT_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [15:0] core_addr;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_be;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    instr_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
        .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_be_i(dbg_be), .dbg_gnt_o(dbg_gnt),
        .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    typedef struct packed {
        int          cyc;
        logic        dbg;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] shadow [256];
    logic [31:0] mem [256];
    logic        mem_init;
    int          cyc;
    int          n_chk;
    int          n_fail;

    function automatic logic [7:0] idx(input logic [15:0] a);
        return {a[15], a[6:0]};
    endfunction

    function automatic logic [31:0] pattern(input int i);
        return {8'hA5, 8'(i), 8'(i ^ 8'h5A), 8'(i + 3)};
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM wrapper model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (ram_en) begin
            ram_rdata <= mem[idx(ram_addr)];
            if (ram_we) mem[idx(ram_addr)] <= apply_be(mem[idx(ram_addr)], ram_wdata, ram_be);
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            if (e.dbg) begin
                chk("dbg_rvalid", dbg_rvalid, 1);
                chk("core_rvalid_off", core_rvalid, 0);
                chk("core_rdata_zero", core_rdata, 0);
                chk("dbg_err", dbg_err, e.err);
                if (e.chk_data) chk("dbg_rdata", dbg_rdata, e.data);
            end else begin
                chk("core_rvalid", core_rvalid, 1);
                chk("dbg_rvalid_off", dbg_rvalid, 0);
                chk("dbg_rdata_zero", dbg_rdata, 0);
                chk("core_rdata", core_rdata, e.data);
            end
        end else begin
            chk("no_rvalid", {core_rvalid, dbg_rvalid, dbg_err}, 0);
        end
    end

    task automatic record(input logic cg, input logic dg, input logic [15:0] ca,
                          input logic dw, input logic [15:0] da, input logic [31:0] dd,
                          input logic [3:0] db, input logic blk, input logic nrsp);
        rsp_t e;
        if (!nrsp && (cg || dg)) begin
            e.cyc      = cyc + 1;
            e.dbg      = dg;
            e.chk_data = !(dg && dw);
            e.data     = dg ? shadow[idx(da)] : shadow[idx(ca)];
            e.err      = blk;
            q.push_back(e);
        end
        if (dg && dw && !blk) shadow[idx(da)] = apply_be(shadow[idx(da)], dd, db);
    endtask

    task automatic step(input logic r, input logic cr, input logic [15:0] ca,
                        input logic dr, input logic dw, input logic [15:0] da,
                        input logic [31:0] dd, input logic [3:0] db,
                        input logic ecg, input logic edg, input logic nrsp);
        logic blk;
        @(posedge clk); #1;
        rst = r; core_req = cr; core_addr = ca;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_be = db;
        @(negedge clk);
        blk = WP && edg && dw && da[15];
        chk("core_gnt", core_gnt, ecg);
        chk("dbg_gnt", dbg_gnt, edg);
        chk("ram_en", ram_en, (ecg | edg) & ~blk);
        if ((ecg || edg) && !blk) begin
            chk("ram_addr", ram_addr, edg ? da : ca);
            chk("ram_we", ram_we, edg & dw);
        end
        record(ecg, edg, ca, dw, da, dd, db, blk, nrsp);
    endtask

    task automatic rand_phase(input int n);
        int          denied;
        logic        cr, dr, dw, blk;
        logic [15:0] ca, da;
        logic [31:0] dd;
        logic [3:0]  db;
        denied = 0;
        for (int i = 0; i < n; i++) begin
            cr = 1'($urandom);
            dr = 1'($urandom);
            dw = 1'($urandom);
            ca = {1'($urandom), 8'h00, 7'($urandom)};
            da = {1'($urandom), 8'h00, 7'($urandom)};
            dd = $urandom;
            db = 4'($urandom);
            @(posedge clk); #1;
            core_req = cr; core_addr = ca;
            dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_be = db;
            @(negedge clk);
            chk("one_gnt", core_gnt & dbg_gnt, 0);
            chk("core_gnt_needs_req", core_gnt & ~cr, 0);
            chk("dbg_gnt_needs_req", dbg_gnt & ~dr, 0);
            if (cr && !dr) chk("core_alone_gnt", core_gnt, 1);
            if (dr && !cr) chk("dbg_alone_gnt", dbg_gnt, 1);
            if (dr && !dbg_gnt) denied++;
            else denied = 0;
            chk("dbg_starve", denied > MAX_WAIT, 0);
            blk = WP && dbg_gnt && dw && da[15];
            chk("rand_ram_en", ram_en, (core_gnt | dbg_gnt) & ~blk);
            record(core_gnt, dbg_gnt, ca, dw, da, dd, db, blk, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        cyc = 0; n_chk = 0; n_fail = 0;
        rst = 1'b1; mem_init = 1'b1; ram_rdata = '0;
        core_req = 0; core_addr = '0; dbg_req = 0; dbg_we = 0;
        dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
        for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
        @(posedge clk); #1 mem_init = 1'b0;

        // reset holds everything quiet even with both requests up
        step(1, 1, 16'h0001, 1, 0, 16'h0002, 0, 4'hF, 0, 0, 0);
        step(1, 1, 16'h0001, 1, 0, 16'h0002, 0, 4'hF, 0, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);

        // core back-to-back reads
        step(0, 1, 16'h0010, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0);
        step(0, 1, 16'h0011, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);

        // core held: dbg forced through on the 5th cycle, core stalls one cycle
        for (int i = 0; i < 4; i++)
            step(0, 1, 16'h0030 + 16'(i), 1, 0, 16'h0020, 0, 4'hF, 1, 0, 0);
        step(0, 1, 16'h0034, 1, 0, 16'h0020, 0, 4'hF, 0, 1, 0);
        step(0, 1, 16'h0034, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);

        // dbg write burst capped at 4, core slips in, dbg resumes
        step(0, 0, 16'h0000, 1, 1, 16'h0040, 32'h1111_1111, 4'hF, 0, 1, 0);
        step(0, 1, 16'h0040, 1, 1, 16'h0041, 32'h2222_2222, 4'h5, 0, 1, 0);
        step(0, 1, 16'h0040, 1, 1, 16'h0042, 32'h3333_3333, 4'hF, 0, 1, 0);
        step(0, 1, 16'h0040, 1, 1, 16'h0043, 32'h4444_4444, 4'hF, 0, 1, 0);
        step(0, 1, 16'h0040, 1, 1, 16'h0044, 32'h5555_5555, 4'hF, 1, 0, 0);
        step(0, 0, 16'h0000, 1, 1, 16'h0044, 32'h5555_5555, 4'hF, 0, 1, 0);
        step(0, 0, 16'h0000, 1, 1, 16'h0045, 32'h6666_6666, 4'hC, 0, 1, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);
        step(0, 1, 16'h0041, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0);
        step(0, 1, 16'h0045, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0);

        // boot-region write then read back
        step(0, 0, 16'h0000, 1, 1, 16'h8004, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
        step(0, 0, 16'h0000, 1, 0, 16'h8004, 0, 4'hF, 0, 1, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);

        // reset clears wait count, kills in-flight responses, returns FSM to CORE_PRIO
        step(0, 1, 16'h0050, 1, 0, 16'h0021, 0, 4'hF, 1, 0, 0);
        step(0, 1, 16'h0050, 1, 0, 16'h0021, 0, 4'hF, 1, 0, 0);
        step(0, 1, 16'h0050, 1, 0, 16'h0021, 0, 4'hF, 1, 0, 1);
        step(1, 1, 16'h0050, 1, 0, 16'h0021, 0, 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 16'h0051, 1, 0, 16'h0021, 0, 4'hF, 1, 0, 0);
        step(0, 1, 16'h0051, 1, 0, 16'h0021, 0, 4'hF, 0, 1, 1);
        step(1, 1, 16'h0051, 1, 0, 16'h0022, 0, 4'hF, 0, 0, 0);
        step(0, 1, 16'h0052, 1, 0, 16'h0022, 0, 4'hF, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);

        rand_phase(400);

        for (int i = 0; i < 3; i++)
            step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0);
        chk("queue_empty", 64'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
